bcd_segment_decoder: RTL and testbench

// - Converts a 4-bit BCD digit into the seven segment drive pattern a..g for one display digit.
// - Sits between the digit counter and the display pin drivers in the 7-segment counter design.
// - The output is registered on clk, so the pins are glitch-free.
// - Codes 10..15 are either blanked or shown as hex A..F, selected by parameter.

---
 rtl/bcd_segment_decoder.sv | 66 ++++++
 tb/tb_bcd_segment_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_segment_decoder.sv
// Registered BCD/hex to seven-segment decoder for one display digit.
// Output bit order is a_g[6]=a ... a_g[0]=g; polarity and handling of codes 10..15 are set by parameters.
module bcd_segment_decoder #(
   parameter int unsigned HEX_MODE   = 0,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] num,
   input  logic       blank,
   output logic [6:0] a_g,
   output logic       err
);

   localparam logic [6:0] OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   logic [6:0] raw;
   logic [6:0] next_seg;
   logic       invalid;
   logic       next_err;

   always_comb begin
      raw     = '0;
      invalid = 1'b0;
      case (num)
         4'd0: raw = 7'h7E;
         4'd1: raw = 7'h30;
         4'd2: raw = 7'h6D;
         4'd3: raw = 7'h79;
         4'd4: raw = 7'h33;
         4'd5: raw = 7'h5B;
         4'd6: raw = 7'h5F;
         4'd7: raw = 7'h70;
         4'd8: raw = 7'h7F;
         4'd9: raw = 7'h7B;
         4'hA: if (HEX_MODE != 0) raw = 7'h77; else invalid = 1'b1;
         4'hB: if (HEX_MODE != 0) raw = 7'h1F; else invalid = 1'b1;
         4'hC: if (HEX_MODE != 0) raw = 7'h4E; else invalid = 1'b1;
         4'hD: if (HEX_MODE != 0) raw = 7'h3D; else invalid = 1'b1;
         4'hE: if (HEX_MODE != 0) raw = 7'h4F; else invalid = 1'b1;
         default: if (HEX_MODE != 0) raw = 7'h47; else invalid = 1'b1;
      endcase
   end

   // Blanking wins over the decode and clears err; inversion is applied last.
   always_comb begin
      next_seg = raw;
      next_err = invalid;
      if (blank) begin
         next_seg = '0;
         next_err = 1'b0;
      end
      if (ACTIVE_LOW != 0) next_seg = ~next_seg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_g <= OFF;
         err <= 1'b0;
      end else begin
         a_g <= next_seg;
         err <= next_err;
      end
   end

endmodule

// File: tb/tb_bcd_segment_decoder.sv
// Self-checking bench: a default instance and a hex/common-anode instance share all inputs,
// each compared against a table-driven behavioural model.
module tb_bcd_segment_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] num = 4'd8;
   logic       blank = 1'b0;
   logic [6:0] a_g0, a_g1;
   logic       err0, err1;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [16];
   logic [7:0] exp0, exp1;

   always #5 clk = ~clk;

   bcd_segment_decoder #(.HEX_MODE(0), .ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst(rst), .num(num), .blank(blank), .a_g(a_g0), .err(err0)
   );

   bcd_segment_decoder #(.HEX_MODE(1), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst(rst), .num(num), .blank(blank), .a_g(a_g1), .err(err1)
   );

   // Returns {segments, err} for a given input and configuration.
   function automatic logic [7:0] model(input logic [3:0] n, input logic b, input bit hex, input bit al);
      logic [6:0] s;
      logic       e;
      s = 7'h00;
      e = 1'b0;
      if (b) s = 7'h00;
      else if (n < 4'd10 || hex) s = seg_tab[n];
      else e = 1'b1;
      if (al) s = ~s;
      return {s, e};
   endfunction

   task automatic drive(input logic [3:0] n, input logic b);
      @(negedge clk);
      num   = n;
      blank = b;
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(4'd8, 1'b0);
      sample();
      sample();
      checks++;
      if ({a_g0, err0} !== 8'h00) begin
         errors++;
         $display("FAIL reset_hold dut0: got a_g=%h err=%b, want a_g=00 err=0", a_g0, err0);
      end
      checks++;
      if ({a_g1, err1} !== {7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL reset_hold dut1: got a_g=%h err=%b, want a_g=7f err=0", a_g1, err1);
      end
      @(negedge clk);
      rst = 1'b1;
      sample();
      exp0 = model(4'd8, 1'b0, 0, 0);
      exp1 = model(4'd8, 1'b0, 1, 1);
      checks++;
      if ({a_g0, err0} !== exp0) begin
         errors++;
         $display("FAIL reset_release dut0: got a_g=%h err=%b, want a_g=%h err=%b", a_g0, err0, exp0[7:1], exp0[0]);
      end
      checks++;
      if ({a_g1, err1} !== exp1) begin
         errors++;
         $display("FAIL reset_release dut1: got a_g=%h err=%b, want a_g=%h err=%b", a_g1, err1, exp1[7:1], exp1[0]);
      end
   endtask

   task automatic test_bcd_sweep();
      for (int i = 0; i < 10; i++) begin
         drive(4'(i), 1'b0);
         sample();
         exp0 = model(4'(i), 1'b0, 0, 0);
         checks++;
         if ({a_g0, err0} !== exp0) begin
            errors++;
            $display("FAIL bcd_sweep num=%0d: got a_g=%h err=%b, want a_g=%h err=%b", i, a_g0, err0, exp0[7:1], exp0[0]);
         end
      end
   endtask

   task automatic test_invalid_and_hex();
      for (int i = 10; i < 16; i++) begin
         drive(4'(i), 1'b0);
         sample();
         exp0 = model(4'(i), 1'b0, 0, 0);
         exp1 = model(4'(i), 1'b0, 1, 1);
         checks++;
         if ({a_g0, err0} !== exp0) begin
            errors++;
            $display("FAIL invalid dut0 num=%0d: got a_g=%h err=%b, want a_g=%h err=%b", i, a_g0, err0, exp0[7:1], exp0[0]);
         end
         checks++;
         if ({a_g1, err1} !== exp1) begin
            errors++;
            $display("FAIL hex dut1 num=%0d: got a_g=%h err=%b, want a_g=%h err=%b", i, a_g1, err1, exp1[7:1], exp1[0]);
         end
      end
      drive(4'd0, 1'b0);
      sample();
      checks++;
      if ({a_g0, err0} !== {7'h7E, 1'b0}) begin
         errors++;
         $display("FAIL invalid_recover dut0: got a_g=%h err=%b, want a_g=7e err=0", a_g0, err0);
      end
   endtask

   task automatic test_blank();
      drive(4'd3, 1'b1);
      sample();
      checks++;
      if ({a_g0, err0} !== 8'h00) begin
         errors++;
         $display("FAIL blank dut0: got a_g=%h err=%b, want a_g=00 err=0", a_g0, err0);
      end
      checks++;
      if ({a_g1, err1} !== {7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL blank dut1: got a_g=%h err=%b, want a_g=7f err=0", a_g1, err1);
      end
      drive(4'd12, 1'b1);
      sample();
      checks++;
      if ({a_g0, err0} !== 8'h00) begin
         errors++;
         $display("FAIL blank_invalid dut0: got a_g=%h err=%b, want a_g=00 err=0", a_g0, err0);
      end
      drive(4'd3, 1'b0);
      sample();
      checks++;
      if ({a_g0, err0} !== {7'h79, 1'b0}) begin
         errors++;
         $display("FAIL blank_release dut0: got a_g=%h err=%b, want a_g=79 err=0", a_g0, err0);
      end
   endtask

   task automatic test_hold();
      drive(4'd6, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if ({a_g0, err0} !== model(4'd6, 1'b0, 0, 0)) begin
            errors++;
            $display("FAIL hold cycle=%0d: got a_g=%h err=%b, want a_g=5f err=0", i, a_g0, err0);
         end
      end
   endtask

   task automatic test_midrun_reset();
      drive(4'd13, 1'b0);
      sample();
      checks++;
      if (err0 !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre err0: got %b, want 1", err0);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({a_g0, err0} !== 8'h00) begin
         errors++;
         $display("FAIL midrun_async dut0: got a_g=%h err=%b, want a_g=00 err=0", a_g0, err0);
      end
      checks++;
      if ({a_g1, err1} !== {7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL midrun_async dut1: got a_g=%h err=%b, want a_g=7f err=0", a_g1, err1);
      end
      @(negedge clk);
      rst = 1'b1;
      num = 4'd2;
      sample();
      checks++;
      if ({a_g0, err0} !== model(4'd2, 1'b0, 0, 0)) begin
         errors++;
         $display("FAIL midrun_release dut0: got a_g=%h err=%b, want a_g=6d err=0", a_g0, err0);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 48; i++) begin
         drive(4'(i % 16), 1'b0);
         sample();
         exp0 = model(4'(i % 16), 1'b0, 0, 0);
         exp1 = model(4'(i % 16), 1'b0, 1, 1);
         checks++;
         if ({a_g0, err0, a_g1, err1} !== {exp0, exp1}) begin
            errors++;
            $display("FAIL wrap num=%0d: got %h/%b %h/%b, want %h/%b %h/%b", i % 16,
                     a_g0, err0, a_g1, err1, exp0[7:1], exp0[0], exp1[7:1], exp1[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] n;
      logic       b;
      for (int i = 0; i < 200; i++) begin
         n = 4'($urandom_range(0, 15));
         b = ($urandom_range(0, 3) == 0);
         drive(n, b);
         // Glitch the input after the edge; only the value at the next edge may matter.
         sample();
         exp0 = model(n, b, 0, 0);
         exp1 = model(n, b, 1, 1);
         num   = 4'($urandom_range(0, 15));
         blank = 1'($urandom_range(0, 1));
         checks++;
         if ({a_g0, err0, a_g1, err1} !== {exp0, exp1}) begin
            errors++;
            $display("FAIL random num=%0d blank=%b: got %h/%b %h/%b, want %h/%b %h/%b", n, b,
                     a_g0, err0, a_g1, err1, exp0[7:1], exp0[0], exp1[7:1], exp1[0]);
         end
      end
   endtask

   initial begin
      seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
      test_reset();
      test_bcd_sweep();
      test_invalid_and_hex();
      test_blank();
      test_hold();
      test_midrun_reset();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
